// File: rtl/rf_wb_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scoreboard_pkg
// Brief    : Shared constants and types for the register-file write-back
//            scoreboard.
// Revision : 1.0  initial release
// ============================================================================
package rf_wb_scoreboard_pkg;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    localparam logic [AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : rf_onehot_dec
// Brief    : Address to one-hot decoder with enable; bit 0 is never driven.
// Revision : 1.0  initial release
// ============================================================================
module rf_onehot_dec #(
    parameter int AW = rf_wb_scoreboard_pkg::AW,
    parameter int NR = rf_wb_scoreboard_pkg::NR
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [NR-1:0] onehot
);
    import rf_wb_scoreboard_pkg::*;

    assign onehot[0] = 1'b0;

    for (genvar i = 1; i < NR; i++) begin : g_bit
        assign onehot[i] = en && (addr == AW'(i));
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_scoreboard
// Brief    : Register-file busy scoreboard with ALU/MEM write-back arbitration
//            onto the single write port and RAW/WAW issue stall.
// Revision : 1.0  initial release
// ============================================================================
module rf_wb_scoreboard #(
    parameter int DW = rf_wb_scoreboard_pkg::DW,
    parameter int NR = rf_wb_scoreboard_pkg::NR,
    parameter int AW = rf_wb_scoreboard_pkg::AW
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          Iss_Valid,
    input  logic [AW-1:0] Iss_Rs,
    input  logic [AW-1:0] Iss_Rt,
    input  logic          Iss_UseRs,
    input  logic          Iss_UseRt,
    input  logic          Iss_Wr,
    input  logic [AW-1:0] Iss_Rd,
    output logic          Iss_Stall,
    input  logic          Alu_Valid,
    input  logic [AW-1:0] Alu_Rd,
    input  logic [DW-1:0] Alu_D,
    input  logic          Mem_Valid,
    input  logic [AW-1:0] Mem_Rd,
    input  logic [DW-1:0] Mem_D,
    output logic          Mem_Ready,
    output logic [DW-1:0] Rf_D,
    output logic [NR-1:0] Rf_En,
    output logic [AW:0]   Pending,
    output logic          Idle,
    output logic          Err
);
    import rf_wb_scoreboard_pkg::*;

    logic [NR-1:0] r_busy;
    logic [AW:0]   r_pending;
    logic          r_err;

    wb_src_e       w_src;
    logic          w_wb_valid;
    logic [AW-1:0] w_wb_rd;
    logic [NR-1:0] w_commit_mask;
    logic [NR-1:0] w_set_mask;
    logic [NR-1:0] w_busy_eff;
    logic          w_hazard;
    logic          w_issue_wr;
    logic          w_wb_err;
    logic          w_inc;
    logic          w_dec;

    // ALU cannot be back-pressured, so it always wins the write port.
    always_comb begin
        w_src = WB_NONE;
        if (!Clr) begin
            if (Alu_Valid)      w_src = WB_ALU;
            else if (Mem_Valid) w_src = WB_MEM;
        end
    end

    always_comb begin
        Rf_D = '0;
        case (w_src)
            WB_ALU:  Rf_D = Alu_D;
            WB_MEM:  Rf_D = Mem_D;
            default: Rf_D = '0;
        endcase
    end

    assign w_wb_valid = (w_src != WB_NONE);
    assign w_wb_rd    = (w_src == WB_MEM) ? Mem_Rd : Alu_Rd;
    assign Mem_Ready  = (w_src == WB_MEM);

    rf_onehot_dec #(.AW(AW), .NR(NR)) u_commit_dec (
        .en     (w_wb_valid),
        .addr   (w_wb_rd),
        .onehot (w_commit_mask)
    );

    assign Rf_En = w_commit_mask;

    // A register committing this cycle is written on the falling edge, ahead
    // of the issue-stage read, so it no longer counts as a hazard.
    assign w_busy_eff = r_busy & ~w_commit_mask;
    assign w_hazard   = (Iss_UseRs & w_busy_eff[Iss_Rs])
                      | (Iss_UseRt & w_busy_eff[Iss_Rt])
                      | (Iss_Wr    & w_busy_eff[Iss_Rd]);
    assign Iss_Stall  = Clr | (Iss_Valid & w_hazard);
    assign w_issue_wr = Iss_Valid & ~Iss_Stall & Iss_Wr;

    rf_onehot_dec #(.AW(AW), .NR(NR)) u_set_dec (
        .en     (w_issue_wr),
        .addr   (Iss_Rd),
        .onehot (w_set_mask)
    );

    assign w_wb_err = w_wb_valid & ((w_wb_rd == REG_ZERO) | ~r_busy[w_wb_rd]);

    // Only commits to busy registers retire a count, keeping Pending equal to
    // the number of busy bits even after a spurious write-back.
    assign w_inc = |w_set_mask;
    assign w_dec = |(w_commit_mask & r_busy);

    always_ff @(posedge Clk) begin
        if (Clr) begin
            r_busy    <= '0;
            r_pending <= '0;
            r_err     <= 1'b0;
        end else begin
            r_busy <= (r_busy & ~w_commit_mask) | w_set_mask;
            case ({w_inc, w_dec})
                2'b10:   r_pending <= r_pending + {{AW{1'b0}}, 1'b1};
                2'b01:   r_pending <= r_pending - {{AW{1'b0}}, 1'b1};
                default: r_pending <= r_pending;
            endcase
            r_err <= r_err | w_wb_err;
        end
    end

    assign Pending = r_pending;
    assign Idle    = (r_pending == '0);
    assign Err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_scoreboard
// Brief    : Directed and random stimulus for rf_wb_scoreboard against a
//            register-array reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rf_wb_scoreboard;

    logic        Clk;
    logic        clr;
    logic        iss_v, iss_urs, iss_urt, iss_wr;
    logic [4:0]  iss_rs, iss_rt, iss_rd;
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        mem_v;
    logic [4:0]  mem_rd;
    logic [31:0] mem_d;

    wire         iss_stall, mem_ready, idle, err;
    wire  [31:0] rf_d, rf_en;
    wire  [5:0]  pending;

    rf_wb_scoreboard dut (
        .Clk       (Clk),
        .Clr       (clr),
        .Iss_Valid (iss_v),
        .Iss_Rs    (iss_rs),
        .Iss_Rt    (iss_rt),
        .Iss_UseRs (iss_urs),
        .Iss_UseRt (iss_urt),
        .Iss_Wr    (iss_wr),
        .Iss_Rd    (iss_rd),
        .Iss_Stall (iss_stall),
        .Alu_Valid (alu_v),
        .Alu_Rd    (alu_rd),
        .Alu_D     (alu_d),
        .Mem_Valid (mem_v),
        .Mem_Rd    (mem_rd),
        .Mem_D     (mem_d),
        .Mem_Ready (mem_ready),
        .Rf_D      (rf_d),
        .Rf_En     (rf_en),
        .Pending   (pending),
        .Idle      (idle),
        .Err       (err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // Reference state: which registers await a write-back, and the sticky error.
    bit mbusy [32];
    bit merr;

    logic        exp_stall, exp_mr, exp_wb;
    logic [4:0]  exp_wrd;
    logic [31:0] exp_en, exp_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pending();
        int n = 0;
        for (int i = 1; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic logic [4:0] pick_busy();
        int start = int'($urandom_range(1, 31));
        for (int k = 0; k < 31; k++) begin
            int r = 1 + ((start - 1 + k) % 31);
            if (mbusy[r]) return 5'(r);
        end
        return 5'($urandom_range(0, 31));
    endfunction

    task automatic quiet();
        clr = 0; iss_v = 0; iss_urs = 0; iss_urt = 0; iss_wr = 0;
        iss_rs = 0; iss_rt = 0; iss_rd = 0;
        alu_v = 0; alu_rd = 0; alu_d = 0;
        mem_v = 0; mem_rd = 0; mem_d = 0;
    endtask

    // One clock: predict, check outputs mid-cycle, then advance the model.
    task automatic cyc();
        bit beff [32];
        exp_wb = 0; exp_mr = 0; exp_wrd = 0; exp_d = 0;
        if (!clr) begin
            if (alu_v)      begin exp_wb = 1; exp_wrd = alu_rd; exp_d = alu_d; end
            else if (mem_v) begin exp_wb = 1; exp_wrd = mem_rd; exp_d = mem_d; exp_mr = 1; end
        end
        exp_en = (exp_wb && exp_wrd != 0) ? (32'd1 << exp_wrd) : 32'd0;
        for (int i = 0; i < 32; i++) beff[i] = mbusy[i] && !(exp_wb && int'(exp_wrd) == i);
        beff[0] = 0;
        exp_stall = clr || (iss_v && ((iss_urs && beff[iss_rs]) || (iss_urt && beff[iss_rt])
                                      || (iss_wr && beff[iss_rd])));
        #2;
        chk("rf_en",   64'(rf_en),     64'(exp_en));
        chk("mem_rdy", 64'(mem_ready), 64'(exp_mr));
        chk("stall",   64'(iss_stall), 64'(exp_stall));
        if (!clr) chk("rf_d", 64'(rf_d), 64'(exp_d));
        chk("pending", 64'(pending),   64'(model_pending()));
        chk("idle",    64'(idle),      64'(model_pending() == 0));
        chk("err",     64'(err),       64'(merr));
        @(posedge Clk);
        if (clr) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
            merr = 0;
        end else begin
            if (exp_wb) begin
                if (exp_wrd == 0 || !mbusy[exp_wrd]) merr = 1;
                if (exp_wrd != 0) mbusy[exp_wrd] = 0;
            end
            if (iss_v && !exp_stall && iss_wr && iss_rd != 0) mbusy[iss_rd] = 1;
        end
        #1;
    endtask

    initial begin
        quiet();
        clr = 1;
        @(posedge Clk); #1;

        // Reset holds off the write port even with an ALU request present.
        clr = 1; alu_v = 1; alu_rd = 5; alu_d = 32'h55;
        cyc(); cyc();
        chk("rst_pending", 64'(pending), 64'd0);

        // RAW stall resolved by a MEM write-back with same-cycle bypass.
        quiet(); iss_v = 1; iss_wr = 1; iss_rd = 3;
        cyc();
        chk("raw_pending1", 64'(pending), 64'd1);
        quiet(); iss_v = 1; iss_urs = 1; iss_rs = 3;
        cyc();
        chk("raw_stall", 64'(exp_stall), 64'd1);
        mem_v = 1; mem_rd = 3; mem_d = 32'hDEADBEEF;
        cyc();
        chk("raw_en", 64'(rf_en), 64'h8);
        quiet(); cyc();
        chk("raw_pending0", 64'(pending), 64'd0);

        // ALU beats MEM; MEM goes through once the ALU is quiet.
        quiet(); iss_v = 1; iss_wr = 1; iss_rd = 4; cyc();
        iss_rd = 7; cyc();
        quiet(); alu_v = 1; alu_rd = 4; alu_d = 32'h11; mem_v = 1; mem_rd = 7; mem_d = 32'h22;
        cyc();
        alu_v = 0; cyc();
        quiet(); cyc();

        // Commit and reissue of the same register in one cycle.
        iss_v = 1; iss_wr = 1; iss_rd = 9; cyc();
        alu_v = 1; alu_rd = 9; alu_d = 32'h99; cyc();
        quiet(); cyc();
        chk("reissue_pending", 64'(pending), 64'd1);
        alu_v = 1; alu_rd = 9; cyc();

        // r0 never becomes busy; a write-back to r0 raises the sticky error.
        quiet(); iss_v = 1; iss_wr = 1; iss_rd = 0; cyc();
        quiet(); alu_v = 1; alu_rd = 0; alu_d = 32'h1234; cyc();
        quiet(); cyc(); cyc();
        chk("r0_err", 64'(err), 64'd1);

        // Spurious write-back to a non-busy register, then clear.
        clr = 1; cyc();
        quiet(); alu_v = 1; alu_rd = 12; alu_d = 32'hC0FFEE; cyc();
        quiet(); clr = 1; cyc();
        quiet(); cyc();

        // Random traffic; MEM holds its request until accepted.
        quiet();
        for (int n = 0; n < 800; n++) begin
            clr     = ($urandom_range(0, 79) == 0);
            iss_v   = $urandom_range(0, 1);
            iss_urs = $urandom_range(0, 1);
            iss_urt = $urandom_range(0, 1);
            iss_wr  = $urandom_range(0, 1);
            iss_rs  = 5'($urandom_range(0, 9));
            iss_rt  = 5'($urandom_range(0, 9));
            iss_rd  = 5'($urandom_range(0, 9));
            alu_v   = ($urandom_range(0, 2) == 0);
            alu_rd  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : pick_busy();
            alu_d   = $urandom;
            if (!mem_v && $urandom_range(0, 1) == 1) begin
                mem_v  = 1;
                mem_rd = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(0, 31)) : pick_busy();
                mem_d  = $urandom;
            end
            cyc();
            if (exp_mr) mem_v = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
